// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (ALU vs load) with in-flight scoreboard.
// Optional statistics counters: define RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard_stall,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rd,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rd,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr_rd,
  output logic [31:0] rf_data_rd,
  output logic [31:0] busy_vec,
  output logic        sb_err,
  output logic [15:0] stat_stall_cnt,
  output logic [15:0] stat_conflict_cnt
);

  logic [3:0]  wait_cnt;
  logic        r0_nz;
  logic        r1_nz;
  logic        r0_win;
  logic        acc0;
  logic        acc1;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] busy_next;
  logic        err_set;

  assign r0_nz  = req0_valid && (req0_rd != 5'd0);
  assign r1_nz  = req1_valid && (req1_rd != 5'd0);
  assign r0_win = (wait_cnt == 4'(MAX_WAIT));

  // x0 requests bypass arbitration entirely
  assign req0_ready = rst_n && req0_valid &&
                      ((req0_rd == 5'd0) || !r1_nz || r0_win);
  assign req1_ready = rst_n && req1_valid &&
                      ((req1_rd == 5'd0) || !r0_nz || !r0_win);

  assign acc0 = req0_ready && r0_nz;
  assign acc1 = req1_ready && r1_nz;

  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    unique case (1'b1)
      acc1: begin
        wr_en   = 1'b1;
        wr_rd   = req1_rd;
        wr_data = req1_data;
      end
      acc0: begin
        wr_en   = 1'b1;
        wr_rd   = req0_rd;
        wr_data = req0_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (issue_valid && (issue_rd != 5'd0))
      set_vec = 32'd1 << issue_rd;
    if (rf_we)
      clr_vec = 32'd1 << rf_addr_rd;
    busy_next = ((busy_vec & ~clr_vec) | set_vec) & ~32'd1;
  end

  // re-issue is legal only when the same edge retires the old write
  assign err_set = issue_valid && (issue_rd != 5'd0) &&
                   busy_vec[issue_rd] && !clr_vec[issue_rd];

  assign hazard_stall = rst_n &&
                        (busy_vec[rs1_addr] || busy_vec[rs2_addr]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_addr_rd <= 5'd0;
      rf_data_rd <= 32'd0;
      busy_vec   <= 32'd0;
      sb_err     <= 1'b0;
      wait_cnt   <= 4'd0;
    end else begin
      rf_we      <= wr_en;
      rf_addr_rd <= wr_rd;
      rf_data_rd <= wr_data;
      busy_vec   <= busy_next;
      if (err_set)
        sb_err <= 1'b1;
      if (acc0)
        wait_cnt <= 4'd0;
      else if (r0_nz)
        wait_cnt <= wait_cnt + 4'd1;
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] conf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
      conf_q  <= 16'd0;
    end else begin
      if (hazard_stall && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (r0_nz && r1_nz && (conf_q != 16'hFFFF))
        conf_q <= conf_q + 16'd1;
    end
  end

  assign stat_stall_cnt    = stall_q;
  assign stat_conflict_cnt = conf_q;
`else
  assign stat_stall_cnt    = 16'd0;
  assign stat_conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: reference model predicts
// readies, stalls and the registered write stream.
module tb_rf_wb_arbiter;

  localparam int MW = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        hazard_stall;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr_rd;
  logic [31:0] rf_data_rd;
  logic [31:0] busy_vec;
  logic        sb_err;
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_conflict_cnt;

  rf_wb_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard_stall(hazard_stall),
    .req0_valid(req0_valid), .req0_rd(req0_rd),
    .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd),
    .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd),
    .rf_data_rd(rf_data_rd), .busy_vec(busy_vec),
    .sb_err(sb_err), .stat_stall_cnt(stat_stall_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  int          m_wait = 0;
  logic [31:0] m_busy = 0;
  logic        m_err = 0;
  logic        m_we = 0;
  logic [4:0]  m_rd = 0;
  int          m_stall = 0;
  int          m_conf = 0;
  logic [36:0] q[$];
  logic        last_a0;
  logic        last_h0;
  logic        last_h1;

  task automatic cyc();
    logic r0nz, r1nz, e_r0, e_r1, e_hz, a0, a1, rst_s;
    logic [31:0] nb;
    logic [36:0] ex;
    @(negedge clk);
    rst_s = rst_n;
    r0nz = req0_valid && (req0_rd != 0);
    r1nz = req1_valid && (req1_rd != 0);
    e_r0 = rst_s && req0_valid &&
           (req0_rd == 0 || !r1nz || m_wait == MW);
    e_r1 = rst_s && req1_valid &&
           (req1_rd == 0 || !r0nz || m_wait != MW);
    e_hz = rst_s && (m_busy[rs1_addr] || m_busy[rs2_addr]);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("hazard_stall", hazard_stall, e_hz);
    a0 = e_r0 && r0nz;
    a1 = e_r1 && r1nz;
    last_a0 = a0;
    last_h0 = e_r0;
    last_h1 = e_r1;
    if (a1) q.push_back({req1_rd, req1_data});
    else if (a0) q.push_back({req0_rd, req0_data});
    nb = m_busy;
    if (m_we) nb[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) begin
      if (m_busy[issue_rd] && !(m_we && m_rd == issue_rd))
        m_err = 1'b1;
      nb[issue_rd] = 1'b1;
    end
    nb[0] = 1'b0;
`ifdef RF_WB_ARB_STATS_EN
    if (e_hz && m_stall < 16'hFFFF) m_stall++;
    if (r0nz && r1nz && m_conf < 16'hFFFF) m_conf++;
`endif
    @(posedge clk);
    #1;
    if (!rst_s) begin
      m_wait = 0; m_busy = 0; m_err = 0;
      m_we = 0; m_rd = 0; m_stall = 0; m_conf = 0;
      q.delete();
      chk("rst_addr", rf_addr_rd, 0);
      chk("rst_data", rf_data_rd, 0);
    end else begin
      m_busy = nb;
      if (a0) m_wait = 0;
      else if (r0nz) m_wait++;
      m_we = a0 || a1;
      m_rd = a1 ? req1_rd : req0_rd;
    end
    if (q.size() > 0) begin
      ex = q.pop_front();
      chk("rf_we", rf_we, 1);
      chk("rf_addr_rd", rf_addr_rd, ex[36:32]);
      chk("rf_data_rd", rf_data_rd, ex[31:0]);
    end else begin
      chk("rf_we_idle", rf_we, 0);
    end
    chk("busy_vec", busy_vec, m_busy);
    chk("sb_err", sb_err, m_err);
    chk("stall_cnt", stat_stall_cnt, m_stall);
    chk("conflict_cnt", stat_conflict_cnt, m_conf);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rd = 0;
    rs1_addr = 0; rs2_addr = 0;
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    cyc();
    cyc();
    rst_n = 1;
  endtask

  logic [3:0] order;

  initial begin
    do_reset();

    // single ALU writeback to x5
    issue_valid = 1; issue_rd = 5;
    cyc();
    issue_valid = 0;
    rs2_addr = 5;
    req0_valid = 1; req0_rd = 5; req0_data = 32'hAA;
    cyc();
    req0_valid = 0;
    cyc();
    cyc();
    chk("x5_cleared", busy_vec[5], 0);

    // sustained conflict: req1 x3 then req0
    req0_valid = 1; req0_rd = 3; req0_data = 32'h3333;
    req1_valid = 1; req1_rd = 4; req1_data = 32'h4444;
    order = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      order[i] = last_a0;
    end
    chk("arb_order", order, 4'b1000);
    idle();
    cyc();

    // x0 request alongside a real one
    req0_valid = 1; req0_rd = 0; req0_data = 32'hDEAD;
    req1_valid = 1; req1_rd = 7; req1_data = 32'h77;
    cyc();
    chk("x0_ready", last_h0, 1);
    chk("x7_ready", last_h1, 1);
    idle();
    cyc();
    cyc();

    // hazard on x9 then same-edge re-issue
    issue_valid = 1; issue_rd = 9;
    cyc();
    issue_valid = 0;
    rs2_addr = 9;
    cyc();
    req1_valid = 1; req1_rd = 9; req1_data = 32'h99;
    cyc();
    req1_valid = 0;
    issue_valid = 1; issue_rd = 9;
    cyc();
    issue_valid = 0;
    cyc();
    chk("x9_still_busy", busy_vec[9], 1);
    chk("x9_no_err", sb_err, 0);
    req0_valid = 1; req0_rd = 9; req0_data = 32'h999;
    cyc();
    req0_valid = 0;
    cyc();
    cyc();

    // double issue of x2 sets the sticky error
    issue_valid = 1; issue_rd = 2;
    cyc();
    cyc();
    issue_valid = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("err_sticky", sb_err, 1);
    do_reset();
    chk("err_cleared", sb_err, 0);

    // reset right after an accept
    req1_valid = 1; req1_rd = 12; req1_data = 32'h1212;
    cyc();
    rst_n = 0;
    idle();
    cyc();
    cyc();
    chk("rst_busy", busy_vec, 0);
    rst_n = 1;
    cyc();
    chk("post_rst_we", rf_we, 0);

    // randomized traffic holding requests until accepted
    for (int i = 0; i < 300; i++) begin
      if (!req0_valid || last_h0) begin
        req0_valid = $urandom_range(0, 1);
        req0_rd = 5'($urandom_range(0, 7));
        req0_data = $urandom;
      end
      if (!req1_valid || last_h1) begin
        req1_valid = $urandom_range(0, 1);
        req1_rd = 5'($urandom_range(0, 7));
        req1_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
